bn_slice_add_seq: RTL and testbench
===================================

# bN_slice_add_seq

Multi-cycle sequencer that adds or subtracts two W = N*K-bit operands by reusing one N-bit ripple-carry slice for K cycles. The slice is built from the team's 1-bit full-adder cells, and a registered carry links consecutive slices. The block trades latency for area: the ALU uses it in place of a full-width ripple adder when the operand width exceeds what one slice should span. It also exercises the team's ripple-carry and overflow rules under sequencing.

## Interface
Parameters:
- N, 4: width of the shared adder slice in bits.
- K, 4: number of slices per operation; K >= 1; W = N*K.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE; a request is accepted on a rising edge where in_valid && in_ready.
- A  in  W  first operand, two's complement or unsigned.
- B  in  W  second operand.
- sub  in  1  0 computes A+B; 1 computes A-B (as A + ~B + 1).
- result  out  W  registered sum or difference.
- carry_out  out  1  carry out of bit W-1; for sub, 1 means no borrow.
- overflow  out  1  signed overflow, equal to carry into bit W-1 XOR carry out of bit W-1.
- out_valid  out  1  result, carry_out and overflow are valid.
- out_ready  in  1  consumer accepts the result on an edge where out_valid && out_ready.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - On accept, latch A into a_reg and (sub ? ~B : B) into b_reg.
  - Load carry_reg with sub; clear idx; clear result, carry_out and overflow.
  - Go to RUN.
- RUN, each cycle:
  - The slice adds a_reg[idx*N +: N], b_reg[idx*N +: N] and carry_reg.
  - Write the slice sum into result[idx*N +: N].
  - Load carry_reg with the slice carry-out.
  - Increment idx.
- RUN, last slice (idx == K-1):
  - Load carry_out with the slice carry-out.
  - Load overflow with slice carry[N] XOR slice carry[N-1], the carries out of the top two bits of the slice.
  - Go to DONE.
- DONE:
  - Hold out_valid high.
  - result, carry_out and overflow stay stable until handshake completes.
  - On out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE; A, B and sub may change freely after accept.
- idx is ceil(log2(K)) bits wide (min 1) and never exceeds K-1.
- Arithmetic is modulo 2^W, and the same hardware serves signed and unsigned use:
  - carry_out gives the unsigned carry or no-borrow.
  - overflow gives the signed result.
- The only adder in the block is the single N-bit slice; no W-bit adder.

## Timing
- Reset values:
  - State IDLE, so in_ready = 1.
  - out_valid = 0, result = 0, carry_out = 0, overflow = 0.
  - a_reg, b_reg, carry_reg and idx all 0.
- Reset mid-RUN or in DONE: outputs return to reset values asynchronously. The operation is discarded and not resumed. After rst falls, the first rising edge may accept a new request.
- Latency: with the accept edge at t0, slices are processed on edges t1..tK. out_valid is high from after edge tK.
- out_valid high with out_ready already high: the handshake completes on edge tK+1, then IDLE.
- Minimum issue interval is K+2 cycles (accept, K RUN cycles, one DONE cycle).
- in_ready is decoded from state only and does not depend on in_valid or out_ready.
- out_valid is a registered state decode; no combinational path from any input to any output.
- Partial result bits may update during RUN. Consumers sample result only while out_valid is high.

## Test plan
- N=4, K=4, A=0x1234, B=0x4321, sub=0:
  - out_valid rises exactly 4 edges after accept.
  - result=0x5555, carry_out=0, overflow=0.
- A=0xFFFF, B=0x0001, sub=0 (carry ripples through all 4 slices): result=0x0000, carry_out=1, overflow=0.
- Signed overflow cases:
  - A=0x7FFF, B=0x0001, sub=0: result=0x8000, overflow=1, carry_out=0.
  - A=0x8000, B=0x0001, sub=1: result=0x7FFF, overflow=1, carry_out=1.
- Subtraction:
  - A=0x0005, B=0x0007, sub=1: result=0xFFFE, carry_out=0, overflow=0.
  - A=B=0x0000, sub=1: result=0x0000, carry_out=1, overflow=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and A/B toggling.
  - Required: result and flags unchanged, in_ready=0, no new accept.
  - Raise out_ready: IDLE on the next edge, then the new request is accepted and computed correctly.
- Reset:
  - Assert rst asynchronously after 2 RUN slices: result, flags and out_valid go to 0 immediately, in_ready=1.
  - After release, run 0x00FF+0x0001: result=0x0100, carry_out=0, overflow=0.
  - Repeat with K=1 (N=4): 0x7+0x1 gives result=0x8, overflow=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/bn_slice_add_seq.sv
// W = N*K bit adder/subtractor that reuses a single N-bit ripple-carry slice for K cycles,
// linking slices through a registered carry.
module bn_slice_add_seq #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4,
    localparam int unsigned W = N * K
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] result_o,
    output logic         carry_out_o,
    output logic         overflow_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(K - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    a_sl, b_sl, sum;
    logic [N:0]      carry;

    // The one and only adder: N chained full-adder cells fed by the registered carry.
    always_comb begin
        a_sl     = a_q[idx_q * N +: N];
        b_sl     = b_q[idx_q * N +: N];
        carry    = '0;
        sum      = '0;
        carry[0] = carry_q;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a_sl[i] ^ b_sl[i] ^ carry[i];
            carry[i + 1] = (a_sl[i] & b_sl[i]) | (carry[i] & (a_sl[i] ^ b_sl[i]));
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d      = a_i;
                    b_d      = sub_i ? ~b_i : b_i;
                    carry_d  = sub_i;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d[idx_q * N +: N] = sum;
                carry_d                  = carry[N];
                if (idx_q == IdxLast) begin
                    cout_d  = carry[N];
                    // carry[N-1] is the carry into bit W-1 on the top slice
                    ovf_d   = carry[N] ^ carry[N-1];
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_bn_slice_add_seq.sv
// Scoreboard bench for bn_slice_add_seq: directed vectors on an N=4,K=4 instance plus a
// short directed check of an N=4,K=1 instance.
module tb_bn_slice_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, cout, ovf, out_valid, out_ready;
    logic [15:0] a, b, result;

    logic        in_valid1, in_ready1, sub1, cout1, ovf1, out_valid1, out_ready1;
    logic [3:0]  a1, b1, result1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    exp_t sb[$];

    bn_slice_add_seq #(.N(4), .K(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .sub_i(sub), .result_o(result), .carry_out_o(cout),
        .overflow_o(ovf), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    bn_slice_add_seq #(.N(4), .K(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .sub_i(sub1), .result_o(result1), .carry_out_o(cout1),
        .overflow_o(ovf1), .out_valid_o(out_valid1), .out_ready_i(out_ready1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endfunction

    // Monitor: compares every cycle out_valid is high (so holds are checked too), pops on handshake.
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got 1 exp 0");
            end else begin
                if (!pv) chk("latency", 32'(cyc - sb[0].acc), 32'd4);
                chk("result", 32'(result), 32'(sb[0].res));
                chk("carry_out", 32'(cout), 32'(sb[0].c));
                chk("overflow", 32'(ovf), 32'(sb[0].v));
                chk("in_ready_done", 32'(in_ready), 32'd0);
                if (out_ready) sb.delete(0);
            end
        end
        pv = !rst && out_valid;
    end

    task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                         input logic [15:0] er, input logic ec, input logic ev);
        int n = 0;
        a        = ai;
        b        = bi;
        sub      = si;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got in_ready 0 exp 1");
        end
        @(posedge clk);
        #1;
        sb.push_back('{er, ec, ev, cyc});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending exp 0", sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[6] = '{
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        a1         = '0;
        b1         = '0;
        sub1       = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({cout, ovf}), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back issues; in_valid re-raised during RUN must be ignored.
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].v);
        drain();

        // Backpressure: hold DONE with new requests pending and operands changing.
        out_ready = 1'b0;
        issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = ~a;
            sub      = a[0];
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_handshake", 32'(in_ready), 32'd1);
        issue(16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1);
        drain();

        // Asynchronous reset after two RUN slices discards the operation.
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_flags", 32'({cout, ovf}), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain();

        // K=1 instance: result one edge after accept.
        in_valid1 = 1'b1;
        a1        = 4'h7;
        b1        = 4'h1;
        sub1      = 1'b0;
        #1;
        chk("k1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("k1_not_yet_valid", 32'(out_valid1), 32'd0);
        @(posedge clk);
        #1;
        chk("k1_out_valid", 32'(out_valid1), 32'd1);
        chk("k1_result", 32'(result1), 32'h8);
        chk("k1_carry_out", 32'(cout1), 32'd0);
        chk("k1_overflow", 32'(ovf1), 32'd1);
        @(posedge clk);
        #1;
        chk("k1_back_idle", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        a1        = 4'hF;
        b1        = 4'h1;
        sub1      = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("k1_sub_result", 32'(result1), 32'hE);
        chk("k1_sub_flags", 32'({cout1, ovf1}), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
